// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// bubble NOP encoding and the per-stage control bundle.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Instruction word bubble consumers load when a bubble/flush is requested.
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_GO = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b0
    };

    localparam stage_ctrl_t CTRL_STOP = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b0
    };

    // Data-memory wait: everything up to EX/MEM frozen, MEM/WB fed a NOP.
    localparam stage_ctrl_t CTRL_DHOLD = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b1
    };

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-high reset.
module pipe_stall_ctrl_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges load-use, memory-busy, redirect and
// halt into per-stage enables/bubbles, tracking memory waits with a small FSM.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exex_stall,
    input  logic             imem_stall,
    input  logic             imem_done,
    input  logic             dmem_en,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    input  logic             branch_taken,
    input  logic             halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             redirect_pend,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             wait_err
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_t              state;
    state_t              state_nxt;
    stage_ctrl_t         ctrl;
    logic                dmem_miss;
    logic                pend_set;
    logic                pend_clr;
    logic                wait_inc;
    logic                wait_clr;
    logic [WAIT_W-1:0]   wait_cnt;

    assign dmem_miss = dmem_en & dmem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stage controls; RUN priority halt > dmem > imem > load-use > branch.
    always_comb begin
        state_nxt = state;
        ctrl      = CTRL_GO;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (halt) begin
                    ctrl      = CTRL_STOP;
                    state_nxt = ST_HALT;
                end else if (dmem_miss) begin
                    ctrl      = CTRL_DHOLD;
                    state_nxt = ST_DWAIT;
                end else if (imem_stall) begin
                    ctrl.pc_en      = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                    state_nxt       = ST_IWAIT;
                end else if (exex_stall) begin
                    ctrl.pc_en       = 1'b0;
                    ctrl.ifid_en     = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                end else begin
                    if (branch_taken) begin
                        ctrl.ifid_flush  = 1'b1;
                        ctrl.idex_bubble = 1'b1;
                    end
                    if (imem_done && redirect_pend) begin
                        ctrl.ifid_flush = 1'b1;
                        pend_clr        = 1'b1;
                    end
                end
            end
            ST_IWAIT: begin
                if (dmem_miss) begin
                    ctrl      = CTRL_DHOLD;
                    pend_set  = branch_taken;
                    state_nxt = ST_DWAIT;
                end else if (imem_done) begin
                    state_nxt = ST_RUN;
                    // Front unfreezes this cycle, so a live redirect acts directly.
                    if (branch_taken) begin
                        ctrl.ifid_flush  = 1'b1;
                        ctrl.idex_bubble = 1'b1;
                    end
                    if (redirect_pend) begin
                        ctrl.ifid_flush = 1'b1;
                        pend_clr        = 1'b1;
                    end
                end else begin
                    ctrl.pc_en      = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                    pend_set        = branch_taken;
                end
            end
            ST_DWAIT: begin
                pend_set = branch_taken;
                if (dmem_done) begin
                    state_nxt = ST_RUN;
                end else begin
                    ctrl = CTRL_DHOLD;
                end
            end
            ST_HALT: begin
                ctrl = CTRL_STOP;
            end
        endcase
        if (rst) begin
            ctrl = CTRL_STOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_pend <= 1'b0;
        end else if (pend_clr) begin
            redirect_pend <= 1'b0;
        end else if (pend_set) begin
            redirect_pend <= 1'b1;
        end
    end

    // Wait counter runs across chained IWAIT/DWAIT and only clears back in RUN.
    assign wait_inc = (state_nxt == ST_IWAIT) || (state_nxt == ST_DWAIT);
    assign wait_clr = (state_nxt == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_err <= 1'b0;
        end else if (wait_inc && !wait_clr && (wait_cnt == WAIT_W'(MAX_WAIT - 1))) begin
            wait_err <= 1'b1;
        end
    end

    pipe_stall_ctrl_sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wait_inc),
        .clr (wait_clr),
        .cnt (wait_cnt)
    );

    pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~ctrl.pc_en & ~rst),
        .clr (1'b0),
        .cnt (stall_cnt)
    );

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign idex_en      = ctrl.idex_en;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_en     = ctrl.memwb_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign halted       = (state == ST_HALT);

endmodule
